raster_setup_pipe: RTL
======================

# raster_setup_pipe

Parametrised triangle-setup stage that replaces the fixed single-mode rasterizer front end. Accepts one screen-space triangle per valid/ready handshake and computes a screen-clamped bounding box, the signed area, and three edge functions evaluated at the bounding-box top-left corner rather than at the origin. It handles winding by configurable back-face culling or by vertex reordering, and drives an external reciprocal unit (`fast_inverse`) for 1/area. Results are held under output backpressure; the block sits between vertex post-transform and the rasterizer back end.

## Interface
- `DATAWIDTH`, 12: signed vertex coordinate width; area and edge values are 2*DATAWIDTH.
- `SCREEN_WIDTH`, 320: x clamp range [0, SCREEN_WIDTH-1].
- `SCREEN_HEIGHT`, 320: y clamp range [0, SCREEN_HEIGHT-1].
- `CULL_BACKFACE`, 1: 1 = discard area<=0; 0 = swap v1/v2 and negate area when area<0, discard only area==0.
- `COUNT_WIDTH`, 16: width of statistics counters.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `i_v0`, `i_v1`, `i_v2`  in  DATAWIDTH x2 each  signed (x,y).
- `in_valid` / `in_ready`  in / out  1  input handshake; `in_ready` = state IDLE and not `rst`.
- `div_ready`  in  1  reciprocal unit can accept.
- `div_a` / `div_a_dv`  out  2*DATAWIDTH / 1  area to invert, one-cycle strobe.
- `div_inv` / `div_inv_dv`  in  2*DATAWIDTH / 1  reciprocal result, strobe.
- `bb_tl`, `bb_br`  out  DATAWIDTH x2 each  clamped box corners.
- `edge_val0..2`  out  2*DATAWIDTH  signed edge values at `bb_tl`.
- `edge_delta0..2`  out  DATAWIDTH x2 each  (dE/dx, dE/dy).
- `o_area`, `area_inv`  out  2*DATAWIDTH  positive area; reciprocal.
- `out_valid` / `out_ready`  out / in  1  output handshake.
- `cull_count`, `emit_count`  out  COUNT_WIDTH  saturating counters.

## Operation
- E(a,b,p) = (px-ax)(by-ay) - (py-ay)(bx-ax); delta = (by-ay, -(bx-ax)). Products are computed at 2*DATAWIDTH with two's-complement wrap, no saturation.
- Area = E(v0,v1,v2). Edge0 = v0→v1, edge1 = v1→v2, edge2 = v2→v0, each evaluated at p = `bb_tl`.
- Bounding box: tl = max(min(x0,x1,x2),0), max(min(y),0); br = min(max(x),SCREEN_WIDTH-1), min(max(y),SCREEN_HEIGHT-1). Box is invalid when tl.x>br.x or tl.y>br.y.
- States and transitions:
  - IDLE: accept on in_valid&&in_ready, latch vertices → AREA.
  - AREA: register area and box → ORIENT.
  - ORIENT, cull case: area==0, box invalid, or (CULL_BACKFACE and area<0) → IDLE, `cull_count`++.
  - ORIENT, otherwise: apply swap/negate if needed; wait for `div_ready`, then pulse `div_a_dv` with positive area → EDGE0.
  - EDGE0 → EDGE1 → EDGE2: one edge per cycle, using the post-swap vertices → WAIT_INV.
  - WAIT_INV: leave once the reciprocal has been captured → OUT.
  - OUT: out_valid=1, all outputs stable; on out_ready → IDLE, `emit_count`++.
- `div_inv_dv` is captured into a sticky register whenever a request is outstanding, including during EDGE0–EDGE2. A strobe with no request outstanding is ignored.
- Counters saturate at all-ones.

## Timing
- Accept edge = T. AREA occupies T+1, ORIENT T+2.
- Culled triangle: `in_ready` is high again at T+3.
- Earliest `div_a_dv` is at T+2. Each extra cycle `div_ready` stays low delays everything after it by one.
- EDGE0–EDGE2 occupy T+3..T+5 and WAIT_INV starts at T+6.
- If the result was captured by T+6, `out_valid` rises at T+7 (minimum latency 7). Otherwise `out_valid` rises the cycle after `div_inv_dv`.
- Throughput: at most one triangle per 8 cycles.
- Reset, including mid-operation: state goes to IDLE, the in-flight triangle is dropped, and the outstanding and sticky flags clear.
- Reset values: `out_valid`=0, `div_a_dv`=0, all data outputs 0, counters 0. `in_ready`=0 while `rst` is high and 1 on the first cycle after.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside OUT.

## Test plan
- CCW triangle (10,10),(10,20),(20,10) with `div_inv_dv` returned at T+6: out_valid at T+7; tl=(10,10), br=(20,20), area=100; edge_val=0,100,0; deltas (10,0),(-10,-10),(0,10); emit_count=1.
- Reversed input (10,10),(20,10),(10,20): with CULL_BACKFACE=0, outputs match the CCW case exactly. With CULL_BACKFACE=1, no out_valid, in_ready=1 at T+3, cull_count=1.
- Off-screen triangle (-30,-30),(-30,-10),(-10,-30) (area 400): culled for an invalid box; div_a_dv never pulses.
- Clamping: (-5,-5),(-5,400),(400,-5) on the 320x320 screen: tl=(0,0), br=(319,319); edge values evaluated at (0,0).
- Backpressure and reciprocal timing:
  - Hold out_ready=0 for 20 cycles: outputs stable, in_ready=0; release → IDLE the next cycle.
  - Return `div_inv_dv` during EDGE0: result retained, out_valid at T+7.
  - Hold `div_ready` low for 5 cycles: out_valid at T+12.
- Pulse rst during EDGE1, then strobe div_inv_dv: no out_valid, counters 0. The next triangle completes correctly.

Source files
------------

// File: rtl/raster_setup_pipe.sv
// raster_setup_pipe: triangle setup producing a clamped bounding box, signed area, top-left edge functions and a reciprocal request
module raster_setup_pipe #(
  parameter int DATAWIDTH     = 12,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int CULL_BACKFACE = 1,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*DATAWIDTH-1:0]   i_v0,
  input  logic [2*DATAWIDTH-1:0]   i_v1,
  input  logic [2*DATAWIDTH-1:0]   i_v2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     div_ready,
  output logic [2*DATAWIDTH-1:0]   div_a,
  output logic                     div_a_dv,
  input  logic [2*DATAWIDTH-1:0]   div_inv,
  input  logic                     div_inv_dv,
  output logic [2*DATAWIDTH-1:0]   bb_tl,
  output logic [2*DATAWIDTH-1:0]   bb_br,
  output logic [2*DATAWIDTH-1:0]   edge_val0,
  output logic [2*DATAWIDTH-1:0]   edge_val1,
  output logic [2*DATAWIDTH-1:0]   edge_val2,
  output logic [2*DATAWIDTH-1:0]   edge_delta0,
  output logic [2*DATAWIDTH-1:0]   edge_delta1,
  output logic [2*DATAWIDTH-1:0]   edge_delta2,
  output logic [2*DATAWIDTH-1:0]   o_area,
  output logic [2*DATAWIDTH-1:0]   area_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COUNT_WIDTH-1:0]   cull_count,
  output logic [COUNT_WIDTH-1:0]   emit_count
);
  localparam int W = DATAWIDTH;
  localparam int D = 2 * DATAWIDTH;
  localparam logic signed [W-1:0] XMAX = W'(SCREEN_WIDTH - 1);
  localparam logic signed [W-1:0] YMAX = W'(SCREEN_HEIGHT - 1);
  typedef enum logic [2:0] {IDLE, AREA, ORIENT, EDGE0, EDGE1, EDGE2, WAIT_INV, OUT} state_t;
  state_t state;
  logic signed [W-1:0] vx [3];
  logic signed [W-1:0] vy [3];
  logic signed [W-1:0] tlx, tly, brx, bry, mnx, mny, mxx, mxy;
  logic signed [W-1:0] ax, ay, bx, by, px, py;
  logic signed [D-1:0] area, e;
  logic [D-1:0] delta;
  logic pending, got, cap, neg, cull;
  function automatic logic signed [D-1:0] sx(input logic signed [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction
  always_comb begin
    mnx = vx[0] < vx[1] ? vx[0] : vx[1];
    mnx = vx[2] < mnx ? vx[2] : mnx;
    mny = vy[0] < vy[1] ? vy[0] : vy[1];
    mny = vy[2] < mny ? vy[2] : mny;
    mxx = vx[0] > vx[1] ? vx[0] : vx[1];
    mxx = vx[2] > mxx ? vx[2] : mxx;
    mxy = vy[0] > vy[1] ? vy[0] : vy[1];
    mxy = vy[2] > mxy ? vy[2] : mxy;
    ax = state == EDGE1 ? vx[1] : state == EDGE2 ? vx[2] : vx[0];
    ay = state == EDGE1 ? vy[1] : state == EDGE2 ? vy[2] : vy[0];
    bx = state == EDGE1 ? vx[2] : state == EDGE2 ? vx[0] : vx[1];
    by = state == EDGE1 ? vy[2] : state == EDGE2 ? vy[0] : vy[1];
    px = state == AREA ? vx[2] : tlx;
    py = state == AREA ? vy[2] : tly;
    e = (sx(px) - sx(ax)) * (sx(by) - sx(ay)) - (sx(py) - sx(ay)) * (sx(bx) - sx(ax));
    delta = {by - ay, ax - bx};
  end
  assign neg       = area[D-1];
  assign cull      = area == '0 || tlx > brx || tly > bry || (CULL_BACKFACE != 0 && neg);
  assign cap       = div_inv_dv && pending;
  assign in_ready  = state == IDLE && !rst;
  assign div_a_dv  = state == ORIENT && !cull && div_ready && !rst;
  assign div_a     = neg ? -area : area;
  assign out_valid = state == OUT;
  assign bb_tl     = {tlx, tly};
  assign bb_br     = {brx, bry};
  assign o_area    = area;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      area        <= '0;
      tlx         <= '0;
      tly         <= '0;
      brx         <= '0;
      bry         <= '0;
      edge_val0   <= '0;
      edge_val1   <= '0;
      edge_val2   <= '0;
      edge_delta0 <= '0;
      edge_delta1 <= '0;
      edge_delta2 <= '0;
      area_inv    <= '0;
      pending     <= 1'b0;
      got         <= 1'b0;
      cull_count  <= '0;
      emit_count  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          vx[0] <= i_v0[D-1:W];
          vy[0] <= i_v0[W-1:0];
          vx[1] <= i_v1[D-1:W];
          vy[1] <= i_v1[W-1:0];
          vx[2] <= i_v2[D-1:W];
          vy[2] <= i_v2[W-1:0];
          state <= AREA;
        end
        AREA: begin
          area  <= e;
          tlx   <= mnx[W-1] ? '0 : mnx;
          tly   <= mny[W-1] ? '0 : mny;
          brx   <= mxx > XMAX ? XMAX : mxx;
          bry   <= mxy > YMAX ? YMAX : mxy;
          state <= ORIENT;
        end
        ORIENT: if (cull) begin
          cull_count <= cull_count + COUNT_WIDTH'(cull_count != '1);
          state      <= IDLE;
        end else if (div_ready) begin
          pending <= 1'b1;
          state   <= EDGE0;
          // clockwise input: swap v1/v2 so the edges see a counter-clockwise triangle
          if (neg) begin
            area  <= -area;
            vx[1] <= vx[2];
            vx[2] <= vx[1];
            vy[1] <= vy[2];
            vy[2] <= vy[1];
          end
        end
        EDGE0: begin
          edge_val0   <= e;
          edge_delta0 <= delta;
          state       <= EDGE1;
        end
        EDGE1: begin
          edge_val1   <= e;
          edge_delta1 <= delta;
          state       <= EDGE2;
        end
        EDGE2: begin
          edge_val2   <= e;
          edge_delta2 <= delta;
          state       <= WAIT_INV;
        end
        WAIT_INV: if (got || cap) state <= OUT;
        OUT: if (out_ready) begin
          emit_count <= emit_count + COUNT_WIDTH'(emit_count != '1);
          got        <= 1'b0;
          state      <= IDLE;
        end
      endcase
      if (cap) begin
        area_inv <= div_inv;
        pending  <= 1'b0;
        got      <= 1'b1;
      end
    end
  end
endmodule
